hough_peak_scanner: RTL
=======================

Name: hough_peak_scanner

Overview:
Reader side of the Hough accumulator BRAM. After the accumulator has finished voting, this block sweeps the BRAM read port once, cell by cell, and tracks the cell with the highest vote count. At the end of the sweep it reports that cell's coordinates, with the image biases added, as the detected circle centre (idealX/idealY). It sits between the accumulator BRAM's port B and the downstream overlay/display logic.

Parameters:
ROW_LENGTH, 450, accumulator cells per row (x extent)
COL_LENGTH, 290, accumulator rows (y extent)
X_BIAS, 95, offset added to cell x to give the image X
Y_BIAS, 95, offset added to cell y to give the image Y
ADDR_W, 18, BRAM address width
DATA_W, 4, vote count width
RD_LATENCY, 2, BRAM read latency in clocks (address edge to valid data)
MIN_VOTES, 1, minimum peak vote count for the result to be valid

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
start  in  1  level-sampled; starts a sweep when sampled high in IDLE
rd_addr  out  ADDR_W  BRAM port-B address
rd_data  in  DATA_W  BRAM port-B data, valid RD_LATENCY clocks after its address
busy  out  1  high from sweep start until done
done  out  1  one-cycle pulse when results update
peak_valid  out  1  last sweep found a peak with value >= MIN_VOTES
peak_value  out  DATA_W  vote count of the reported peak
idealX  out  10  peak x + X_BIAS
idealY  out  9  peak y + Y_BIAS

Behaviour:
- Reset (asynchronous, any state, including mid-sweep):
  - state=IDLE.
  - rd_addr, busy, done, peak_valid, peak_value, idealX, idealY all 0.
  - Pipeline valid bits cleared.
- FSM IDLE -> SCAN -> DRAIN -> DONE -> IDLE.
- IDLE:
  - rd_addr=0.
  - start sampled high at edge E0: enter SCAN, busy=1, clear the running best (best value 0, no candidate).
- SCAN:
  - rd_addr advances by +1 each clock: 0 after E0, last address ROW_LENGTH*COL_LENGTH-1 after edge E0+N-1, where N=ROW_LENGTH*COL_LENGTH.
  - Internal x/y counters track the address without a multiplier.
  - x wraps ROW_LENGTH-1 -> 0, and y increments at the same time.
  - Each issued address pushes (valid, x, y) into a RD_LATENCY-deep delay line aligned with rd_data.
  - After the last address: enter DRAIN, and rd_addr holds the last address.
- DRAIN:
  - Wait RD_LATENCY clocks so the final data word is compared.
  - Then enter DONE.
- Compare rule:
  - When delayed valid=1 and rd_data > best value (strict), update best value, x and y.
  - Ties keep the earlier cell in scan order (lowest address wins).
- DONE (one clock):
  - done=1 and busy=0.
  - If best value >= MIN_VOTES: peak_valid=1, peak_value=best, idealX=x+X_BIAS, idealY=y+Y_BIAS.
  - Else: peak_valid=0, peak_value=best, and idealX/idealY hold their previous values.
  - Then return to IDLE.
- Timing: done is high in the cycle following edge E0+N+RD_LATENCY. Total sweep is N+RD_LATENCY+1 clocks.
- start is ignored while busy or in DONE; a held start begins a new sweep from IDLE on the next edge.
- Outputs remain stable between done pulses.
- Bias arithmetic: unsigned.
  - x+X_BIAS computed in 10 bits, y+Y_BIAS in 9 bits.
  - Defaults give at most 544 and 384, so there is no overflow.
  - Other parameter choices must keep the sums in range; overflowing values truncate.
- The block never writes the BRAM; port A belongs exclusively to the accumulator writer.
- The scan must not overlap accumulator writes. Sequencing is the controller's job; this block does not check it.

Test Plan:
Setup for all scenarios: ROW_LENGTH=8, COL_LENGTH=4, RD_LATENCY=2, X_BIAS=Y_BIAS=95, MIN_VOTES=1, behavioural 2-cycle BRAM model.
1. Single peak: memory all 0, addr 19 = 9 -> done exactly at cycle E0+35, peak_valid=1, peak_value=9, idealX=98, idealY=97; rd_addr sequence 0..31, each address once.
2. Tie: addr 5=7 and addr 20=7, others 0 -> idealX=100, idealY=95 (the earlier cell wins), peak_value=7.
3. Last-cell peak: addr 31=15 (drain boundary) -> idealX=102, idealY=98, peak_value=15.
4. Below threshold: run scenario 1, then rerun with MIN_VOTES=3 and memory max=2 -> peak_valid=0, peak_value=2, idealX/Y stay 98/97.
5. start pulsed repeatedly during the sweep -> no restart, single done pulse, rd_addr strictly increasing; start held high through DONE -> the next sweep begins one cycle after done.
6. rst_n asserted while rd_addr=10 -> all outputs 0 immediately (asynchronous); after release, start plus scenario 1 memory -> correct result with done at E0+35.

Source files
------------

// File: rtl/hough_peak_scanner_if.sv
// hough_peak_scanner_if
// Groups the signals between the peak scanner and its surroundings: the
// start/busy/done handshake with the controller, the BRAM port-B read bus
// and the detected-centre result.
//
//   start       controller -> scanner, level-sampled sweep request
//   rd_addr     scanner -> BRAM, port-B read address
//   rd_data     BRAM -> scanner, vote count for an earlier address
//   busy, done  scanner -> controller, sweep status and completion pulse
//   peak_valid, peak_value, idealX, idealY
//               scanner -> overlay logic, last sweep's result
//
// The master modport is the scanner itself; slave is the other side.
interface hough_peak_scanner_if #(
   parameter int ADDR_W = 18,
   parameter int DATA_W = 4
);
   logic              start;
   logic [ADDR_W-1:0] rd_addr;
   logic [DATA_W-1:0] rd_data;
   logic              busy;
   logic              done;
   logic              peak_valid;
   logic [DATA_W-1:0] peak_value;
   logic [9:0]        idealX;
   logic [8:0]        idealY;

   modport master (
      input  start, rd_data,
      output rd_addr, busy, done, peak_valid, peak_value, idealX, idealY
   );

   modport slave (
      output start, rd_data,
      input  rd_addr, busy, done, peak_valid, peak_value, idealX, idealY
   );
endinterface

// File: rtl/hough_peak_scanner.sv
// hough_peak_scanner
// Read side of the Hough accumulator BRAM. On start it walks port B once
// over every accumulator cell in address order, keeps the cell with the
// strictly highest vote count (earliest cell wins a tie) and, at the end of
// the sweep, reports that cell's coordinates plus the image biases as the
// detected circle centre.
//
// Ports:
//   clk    system clock, rising edge
//   rst_n  asynchronous active-low reset
//   bus    hough_peak_scanner_if.master: start, rd_addr, rd_data, busy,
//          done, peak_valid, peak_value, idealX, idealY
//
// The interface instance must use the same ADDR_W/DATA_W as this module.
module hough_peak_scanner #(
   parameter int ROW_LENGTH = 450,
   parameter int COL_LENGTH = 290,
   parameter int X_BIAS     = 95,
   parameter int Y_BIAS     = 95,
   parameter int ADDR_W     = 18,
   parameter int DATA_W     = 4,
   parameter int RD_LATENCY = 2,
   parameter int MIN_VOTES  = 1
) (
   input logic                  clk,
   input logic                  rst_n,
   hough_peak_scanner_if.master bus
);

   localparam int N  = ROW_LENGTH * COL_LENGTH;
   localparam int XW = (ROW_LENGTH > 1) ? $clog2(ROW_LENGTH) : 1;
   localparam int YW = (COL_LENGTH > 1) ? $clog2(COL_LENGTH) : 1;
   localparam int DW = (RD_LATENCY > 1) ? $clog2(RD_LATENCY) : 1;

   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(N - 1);
   localparam logic [XW-1:0]     X_LAST    = XW'(ROW_LENGTH - 1);
   localparam logic [DW-1:0]     DRAIN_END = DW'(RD_LATENCY - 1);
   localparam logic [31:0]       MIN_U     = 32'(MIN_VOTES);

   typedef enum logic [1:0] {
      IDLE,
      SCAN,
      DRAIN,
      DONE
   } state_t;

   state_t state;

   // Coordinates of the address currently on rd_addr.
   logic [XW-1:0] cur_x;
   logic [YW-1:0] cur_y;

   // Delay line of (valid, x, y) tags. Entry 0 is loaded together with
   // rd_addr; entry RD_LATENCY-1 lines up with the rd_data of that address.
   logic          tag_valid [RD_LATENCY];
   logic [XW-1:0] tag_x     [RD_LATENCY];
   logic [YW-1:0] tag_y     [RD_LATENCY];

   logic [DATA_W-1:0] best_value;
   logic [XW-1:0]     best_x;
   logic [YW-1:0]     best_y;
   logic [DW-1:0]     drain_cnt;

   logic          x_wrap;
   logic [XW-1:0] next_x;
   logic [YW-1:0] next_y;

   // Row/column stepping for the next address: x counts along the row and
   // y steps once per wrap, so no multiplier is needed to recover (x, y).
   always_comb begin
      x_wrap = (cur_x == X_LAST);
      next_x = x_wrap ? '0 : cur_x + XW'(1);
      next_y = x_wrap ? cur_y + YW'(1) : cur_y;
   end

   // Sweep sequencer, read-tag delay line, running-maximum tracker and the
   // registered result outputs. The compare runs every cycle but only acts
   // on tagged data, so idle-time BRAM output is never considered.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state          <= IDLE;
         bus.rd_addr    <= '0;
         bus.busy       <= 1'b0;
         bus.done       <= 1'b0;
         bus.peak_valid <= 1'b0;
         bus.peak_value <= '0;
         bus.idealX     <= '0;
         bus.idealY     <= '0;
         cur_x          <= '0;
         cur_y          <= '0;
         best_value     <= '0;
         best_x         <= '0;
         best_y         <= '0;
         drain_cnt      <= '0;
         for (int i = 0; i < RD_LATENCY; i++) begin
            tag_valid[i] <= 1'b0;
            tag_x[i]     <= '0;
            tag_y[i]     <= '0;
         end
      end else begin
         for (int i = 1; i < RD_LATENCY; i++) begin
            tag_valid[i] <= tag_valid[i-1];
            tag_x[i]     <= tag_x[i-1];
            tag_y[i]     <= tag_y[i-1];
         end
         tag_valid[0] <= 1'b0;
         bus.done     <= 1'b0;

         // Strict greater-than keeps the earliest cell on equal counts.
         if (tag_valid[RD_LATENCY-1] && (bus.rd_data > best_value)) begin
            best_value <= bus.rd_data;
            best_x     <= tag_x[RD_LATENCY-1];
            best_y     <= tag_y[RD_LATENCY-1];
         end

         case (state)
            IDLE: begin
               bus.rd_addr <= '0;
               if (bus.start) begin
                  state        <= SCAN;
                  bus.busy     <= 1'b1;
                  best_value   <= '0;
                  best_x       <= '0;
                  best_y       <= '0;
                  cur_x        <= '0;
                  cur_y        <= '0;
                  tag_valid[0] <= 1'b1;
                  tag_x[0]     <= '0;
                  tag_y[0]     <= '0;
               end
            end

            SCAN: begin
               if (bus.rd_addr == LAST_ADDR) begin
                  state     <= DRAIN;
                  drain_cnt <= '0;
               end else begin
                  bus.rd_addr  <= bus.rd_addr + ADDR_W'(1);
                  cur_x        <= next_x;
                  cur_y        <= next_y;
                  tag_valid[0] <= 1'b1;
                  tag_x[0]     <= next_x;
                  tag_y[0]     <= next_y;
               end
            end

            // The last address's data is compared on the final DRAIN edge
            // before this one, so best_* is settled when results are taken.
            DRAIN: begin
               if (drain_cnt == DRAIN_END) begin
                  state          <= DONE;
                  bus.busy       <= 1'b0;
                  bus.done       <= 1'b1;
                  bus.peak_value <= best_value;
                  if (32'(best_value) >= MIN_U) begin
                     bus.peak_valid <= 1'b1;
                     bus.idealX     <= 10'(32'(best_x) + X_BIAS);
                     bus.idealY     <= 9'(32'(best_y) + Y_BIAS);
                  end else begin
                     bus.peak_valid <= 1'b0;
                  end
               end else begin
                  drain_cnt <= drain_cnt + DW'(1);
               end
            end

            DONE: begin
               state       <= IDLE;
               bus.rd_addr <= '0;
            end

            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule
